mvu_job_launcher: RTL and testbench

- Per-MVU job sequencer that sits directly upstream of one MVU slice.
- Accepts job descriptors from the host/CSR side through a valid/ready port and buffers them in a small FIFO.
- For each job it drives the MVU config fields, clears the accumulator and quantizer, pulses start, then waits for done.
- On completion it raises a sticky irq and counts finished jobs. A watchdog aborts jobs that never complete.

---
 rtl/mvu_job_launcher.sv | 181 ++++++++++++++++++
 tb/tb_mvu_job_launcher.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_job_launcher.sv
// Job sequencer in front of one MVU slice: buffers descriptors, then runs
// configure / clear / start / wait-for-done for each one, with a watchdog.
module mvu_job_launcher #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BCNTDWN  = 29,
    parameter int unsigned BPREC    = 6,
    parameter int unsigned BBWADDR  = 9,
    parameter int unsigned BBDADDR  = 9,
    parameter int unsigned BQMSBIDX = 5,
    parameter int unsigned BTIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BCNTDWN-1:0]  cmd_countdown,
    input  logic [BPREC-1:0]    cmd_wprecision,
    input  logic [BPREC-1:0]    cmd_iprecision,
    input  logic [BPREC-1:0]    cmd_oprecision,
    input  logic [BBWADDR-1:0]  cmd_wbaseaddr,
    input  logic [BBDADDR-1:0]  cmd_ibaseaddr,
    input  logic [BBDADDR-1:0]  cmd_obaseaddr,
    input  logic [BQMSBIDX-1:0] cmd_quant_msbidx,
    input  logic [1:0]          cmd_mul_mode,
    output logic [BCNTDWN-1:0]  countdown,
    output logic [BPREC-1:0]    wprecision,
    output logic [BPREC-1:0]    iprecision,
    output logic [BPREC-1:0]    oprecision,
    output logic [BBWADDR-1:0]  wbaseaddr,
    output logic [BBDADDR-1:0]  ibaseaddr,
    output logic [BBDADDR-1:0]  obaseaddr,
    output logic [BQMSBIDX-1:0] quant_msbidx,
    output logic [1:0]          mul_mode,
    output logic                shacc_clr,
    output logic                quant_clr,
    output logic                start,
    input  logic                done,
    output logic                irq,
    input  logic                irq_clr,
    input  logic [BTIMEOUT-1:0] timeout_limit,
    output logic                timeout_err,
    input  logic                err_clr,
    output logic                busy,
    output logic [15:0]         jobs_done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = BCNTDWN + 3 * BPREC + BBWADDR + 2 * BBDADDR + BQMSBIDX + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CFG   = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [PW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic                empty_q;
    logic                push;
    logic                pop;
    logic                done_hit;
    logic                timeout_hit;
    logic [BTIMEOUT-1:0] wd_cnt;

    assign push       = cmd_valid && cmd_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; empty_q lags the count by one cycle so a fresh
    // entry has settled in the buffer before IDLE consumes it.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    state_next = S_CFG;
                end
            end
            S_CFG:   state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN: begin
                if (done) begin
                    done_hit   = 1'b1;
                    state_next = S_IDLE;
                end else if ((timeout_limit != '0) &&
                             (wd_cnt == timeout_limit - BTIMEOUT'(1))) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Descriptor storage; contents need no reset, occupancy is tracked below
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_countdown, cmd_wprecision, cmd_iprecision, cmd_oprecision,
                            cmd_wbaseaddr, cmd_ibaseaddr, cmd_obaseaddr,
                            cmd_quant_msbidx, cmd_mul_mode};
        end
    end

    // FIFO bookkeeping, config registers, pulses, watchdog and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty_q      <= 1'b1;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            countdown    <= '0;
            wprecision   <= '0;
            iprecision   <= '0;
            oprecision   <= '0;
            wbaseaddr    <= '0;
            ibaseaddr    <= '0;
            obaseaddr    <= '0;
            quant_msbidx <= '0;
            mul_mode     <= '0;
            shacc_clr    <= 1'b0;
            quant_clr    <= 1'b0;
            start        <= 1'b0;
            wd_cnt       <= '0;
            irq          <= 1'b0;
            timeout_err  <= 1'b0;
            jobs_done    <= '0;
        end else begin
            count     <= count_next;
            empty_q   <= (count == '0);
            cmd_ready <= (count_next != CW'(DEPTH));
            busy      <= (state_next != S_IDLE) || (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {countdown, wprecision, iprecision, oprecision, wbaseaddr,
                 ibaseaddr, obaseaddr, quant_msbidx, mul_mode} <= mem[rd_ptr];
            end
            shacc_clr <= (state_next == S_CFG);
            quant_clr <= (state_next == S_CFG);
            start     <= (state_next == S_START);
            if (state == S_START) begin
                wd_cnt <= '0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + BTIMEOUT'(1);
            end
            if (done_hit) begin
                irq       <= 1'b1;
                jobs_done <= jobs_done + 16'd1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mvu_job_launcher.sv
// Bench for mvu_job_launcher: directed scenarios plus random traffic, all
// checked every cycle against a queue-based job model.
module tb_mvu_job_launcher;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [28:0] cd;
        logic [5:0]  wp;
        logic [5:0]  ip;
        logic [5:0]  op;
        logic [8:0]  wb;
        logic [8:0]  ib;
        logic [8:0]  ob;
        logic [4:0]  qm;
        logic [1:0]  mm;
    } job_t;

    typedef struct packed {
        job_t        d;
        int unsigned t;
    } ent_t;

    typedef struct packed {
        int unsigned e;
        logic [28:0] cd;
    } sev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    job_t        drv = '0;
    logic [28:0] countdown;
    logic [5:0]  wprecision, iprecision, oprecision;
    logic [8:0]  wbaseaddr, ibaseaddr, obaseaddr;
    logic [4:0]  quant_msbidx;
    logic [1:0]  mul_mode;
    logic        shacc_clr, quant_clr, start;
    logic        done = 1'b0;
    logic        irq;
    logic        irq_clr = 1'b0;
    logic [31:0] timeout_limit = '0;
    logic        timeout_err;
    logic        err_clr = 1'b0;
    logic        busy;
    logic [15:0] jobs_done;

    always #5 clk = ~clk;

    mvu_job_launcher #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_countdown(drv.cd), .cmd_wprecision(drv.wp), .cmd_iprecision(drv.ip),
        .cmd_oprecision(drv.op), .cmd_wbaseaddr(drv.wb), .cmd_ibaseaddr(drv.ib),
        .cmd_obaseaddr(drv.ob), .cmd_quant_msbidx(drv.qm), .cmd_mul_mode(drv.mm),
        .countdown(countdown), .wprecision(wprecision), .iprecision(iprecision),
        .oprecision(oprecision), .wbaseaddr(wbaseaddr), .ibaseaddr(ibaseaddr),
        .obaseaddr(obaseaddr), .quant_msbidx(quant_msbidx), .mul_mode(mul_mode),
        .shacc_clr(shacc_clr), .quant_clr(quant_clr), .start(start), .done(done),
        .irq(irq), .irq_clr(irq_clr), .timeout_limit(timeout_limit),
        .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy), .jobs_done(jobs_done)
    );

    int          nerr = 0;
    int          nchecks = 0;
    bit          chk_en = 1'b0;
    int unsigned ecnt = 0;
    sev_t        starts[$];

    // Model: queue of descriptors, plus the edge at which the current job was loaded
    ent_t        q[$];
    bit          m_active = 1'b0;
    int unsigned m_l = 0;
    job_t        m_cfg = '0;
    bit          m_irq = 1'b0;
    bit          m_err = 1'b0;
    bit          m_ready = 1'b1;
    logic [15:0] m_jobs = '0;
    bit          fin_done, fin_to;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A job is loaded two edges after its push, runs CFG, START, then RUN until
    // done or until it has spent timeout_limit cycles in RUN.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_active = 1'b0;
            m_cfg    = '0;
            m_irq    = 1'b0;
            m_err    = 1'b0;
            m_ready  = 1'b1;
            m_jobs   = '0;
        end else begin
            ecnt++;
            fin_done = 1'b0;
            fin_to   = 1'b0;
            if (m_active) begin
                if (ecnt - m_l >= 3) begin
                    if (done) fin_done = 1'b1;
                    else if (timeout_limit != 0 && ecnt - m_l - 2 == timeout_limit) fin_to = 1'b1;
                end
                if (fin_done || fin_to) m_active = 1'b0;
            end else if (q.size() > 0 && q[0].t + 2 <= ecnt) begin
                m_cfg    = q[0].d;
                void'(q.pop_front());
                m_active = 1'b1;
                m_l      = ecnt;
            end
            if (fin_done) begin
                m_irq  = 1'b1;
                m_jobs = m_jobs + 16'd1;
            end else if (irq_clr) begin
                m_irq = 1'b0;
            end
            if (fin_to) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (cmd_valid && m_ready) q.push_back({drv, ecnt});
            m_ready = (q.size() != DEPTH);
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 128'(cmd_ready), 128'(m_ready));
            check("shacc_clr", 128'(shacc_clr), 128'(m_active && ecnt == m_l));
            check("quant_clr", 128'(quant_clr), 128'(m_active && ecnt == m_l));
            check("start", 128'(start), 128'(m_active && ecnt == m_l + 1));
            check("busy", 128'(busy), 128'(m_active || q.size() != 0));
            check("irq", 128'(irq), 128'(m_irq));
            check("timeout_err", 128'(timeout_err), 128'(m_err));
            check("jobs_done", 128'(jobs_done), 128'(m_jobs));
            check("config", 128'({countdown, wprecision, iprecision, oprecision, wbaseaddr,
                                  ibaseaddr, obaseaddr, quant_msbidx, mul_mode}), 128'(m_cfg));
        end
    end

    always @(negedge clk) begin
        if (rst_n && start) starts.push_back({ecnt, countdown});
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic job_t rnd_job();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[80:0];
    endfunction

    task automatic push_job(input job_t j, output int unsigned n);
        bit ok;
        n = 0;
        drv = j;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ok = cmd_ready;
            tick(1);
            if (ok) begin
                n = ecnt;
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        nchecks++;
        nerr++;
        $display("FAIL push_accept: descriptor not accepted within 100 cycles");
    endtask

    task automatic wait_start(input string nm, output int unsigned s, output logic [28:0] cd);
        s = 0;
        cd = '0;
        for (int i = 0; i < 100 && starts.size() == 0; i++) tick(1);
        if (starts.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL %s: no start within 100 cycles", nm);
        end else begin
            s  = starts[0].e;
            cd = starts[0].cd;
            void'(starts.pop_front());
        end
    endtask

    task automatic pulse_done_at(input int unsigned e);
        for (int i = 0; i < 100 && ecnt < e; i++) tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    job_t        j;
    job_t        jobs5[5];
    int unsigned n, s, s2, t;
    logic [28:0] cd;

    initial begin
        tick(2);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_start", 128'(start), 128'(0));
        check("rst_jobs_done", 128'(jobs_done), 128'(0));
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // Single job
        j = rnd_job();
        j.cd = 29'd10;
        j.wb = 9'h12;
        push_job(j, n);
        wait_start("single_start", s, cd);
        check("single_latency", 128'(s - n), 128'(3));
        check("single_countdown", 128'(countdown), 128'(10));
        check("single_wbase", 128'(wbaseaddr), 128'(9'h12));
        tick(1);
        check("single_start_width", 128'(start), 128'(0));
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("single_irq", 128'(irq), 128'(1));
        check("single_jobs", 128'(jobs_done), 128'(1));
        check("single_busy", 128'(busy), 128'(0));

        // Five jobs pushed back to back, done withheld until each start
        for (int k = 0; k < 5; k++) begin
            jobs5[k] = rnd_job();
            push_job(jobs5[k], n);
        end
        check("fifo_full_ready", 128'(cmd_ready), 128'(0));
        for (int k = 0; k < 5; k++) begin
            wait_start("five_start", s, cd);
            check("five_order", 128'(cd), 128'(jobs5[k].cd));
            pulse_done_at(s + 2);
        end
        tick(1);
        check("five_jobs", 128'(jobs_done), 128'(6));

        // Watchdog, with a second job queued behind the hung one
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        timeout_limit = 32'd20;
        push_job(rnd_job(), n);
        push_job(rnd_job(), n);
        wait_start("wd_start", s, cd);
        t = 0;
        for (int i = 0; i < 100 && !timeout_err; i++) tick(1);
        t = ecnt;
        check("wd_seen", 128'(timeout_err), 128'(1));
        check("wd_delay", 128'(t - s), 128'(21));
        check("wd_no_irq", 128'(irq), 128'(0));
        wait_start("wd_next_start", s2, cd);
        check("wd_next_latency", 128'(s2 - t), 128'(2));
        pulse_done_at(s2 + 2);
        check("wd_jobs", 128'(jobs_done), 128'(7));
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("wd_err_clr", 128'(timeout_err), 128'(0));
        timeout_limit = '0;

        // irq set wins over same-cycle clear
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        check("irq_cleared", 128'(irq), 128'(0));
        push_job(rnd_job(), n);
        wait_start("irq_start", s, cd);
        for (int i = 0; i < 10 && ecnt < s + 2; i++) tick(1);
        done = 1'b1;
        irq_clr = 1'b1;
        tick(1);
        done = 1'b0;
        irq_clr = 1'b0;
        check("irq_set_priority", 128'(irq), 128'(1));
        tick(2);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        check("irq_clear_later", 128'(irq), 128'(0));

        // done during CFG and START is ignored
        starts.delete();
        push_job(rnd_job(), n);
        tick(2);
        done = 1'b1;
        tick(2);
        done = 1'b0;
        check("spurious_jobs", 128'(jobs_done), 128'(8));
        check("spurious_busy", 128'(busy), 128'(1));
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("spurious_then_run_done", 128'(jobs_done), 128'(9));

        // Reset during RUN with two jobs queued
        starts.delete();
        for (int k = 0; k < 3; k++) push_job(rnd_job(), n);
        wait_start("rst_job_start", s, cd);
        for (int i = 0; i < 10 && ecnt < s + 2; i++) tick(1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 128'(cmd_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_jobs", 128'(jobs_done), 128'(0));
        check("midrst_countdown", 128'(countdown), 128'(0));
        tick(2);
        starts.delete();
        rst_n = 1'b1;
        tick(20);
        check("no_start_after_rst", 128'(starts.size()), 128'(0));
        check("idle_after_rst", 128'(busy), 128'(0));

        // Random traffic: first without watchdog, then with a short one
        for (int ph = 0; ph < 2; ph++) begin
            timeout_limit = (ph == 0) ? 32'd0 : 32'd7;
            for (int c = 0; c < 1500; c++) begin
                drv       = rnd_job();
                cmd_valid = ($urandom_range(2) == 0);
                done      = ($urandom_range(7) == 0);
                irq_clr   = ($urandom_range(15) == 0);
                err_clr   = ($urandom_range(15) == 0);
                tick(1);
            end
        end
        cmd_valid = 1'b0;
        done = 1'b0;
        irq_clr = 1'b0;
        err_clr = 1'b0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
